axi_nmaster_arbiter: RTL and testbench

- Parametrised N-master to single-AXI-slave arbiter. It is the next-generation CPU-to-bus bridge: icache, dcache and uncached ports each present a simplified AXI master interface, and the block merges them onto one AXI master port toward the SoC.
- Read and write paths are independent.
- Each path uses round-robin arbitration and holds its grant for the whole transaction.

---
 rtl/axi_nmaster_arbiter.sv | 253 +++++++++++++++++++++++++
 tb/tb_axi_nmaster_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_nmaster_arbiter.sv
// N-master to single-slave AXI arbiter: independent read/write paths, each with
// round-robin grant held from address phase to last data beat (read) or B response (write).
//
// state  | meaning
// R_IDLE | no read owner, arbitrate among s_arvalid
// R_ADDR | forward granted AR to slave
// R_DATA | route R beats to granted master until rlast
// W_IDLE | no write owner, arbitrate among s_awvalid
// W_ADDR | forward granted AW; W held off
// W_DATA | forward granted W beats until wlast
// W_RESP | route B response to granted master
module axi_nmaster_arbiter #(
   parameter int N_MST  = 3,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   // upstream read
   input  logic [N_MST-1:0]           s_arvalid,
   output logic [N_MST-1:0]           s_arready,
   input  logic [N_MST*ADDR_W-1:0]    s_araddr,
   input  logic [N_MST*8-1:0]         s_arlen,
   input  logic [N_MST*3-1:0]         s_arsize,
   output logic [DATA_W-1:0]          s_rdata,
   output logic [1:0]                 s_rresp,
   output logic                       s_rlast,
   output logic [N_MST-1:0]           s_rvalid,
   input  logic [N_MST-1:0]           s_rready,
   // upstream write
   input  logic [N_MST-1:0]           s_awvalid,
   output logic [N_MST-1:0]           s_awready,
   input  logic [N_MST*ADDR_W-1:0]    s_awaddr,
   input  logic [N_MST*8-1:0]         s_awlen,
   input  logic [N_MST*3-1:0]         s_awsize,
   input  logic [N_MST*DATA_W-1:0]    s_wdata,
   input  logic [N_MST*DATA_W/8-1:0]  s_wstrb,
   input  logic [N_MST-1:0]           s_wlast,
   input  logic [N_MST-1:0]           s_wvalid,
   output logic [N_MST-1:0]           s_wready,
   output logic [1:0]                 s_bresp,
   output logic [N_MST-1:0]           s_bvalid,
   input  logic [N_MST-1:0]           s_bready,
   // downstream read
   output logic [ID_W-1:0]            m_arid,
   output logic [ADDR_W-1:0]          m_araddr,
   output logic [7:0]                 m_arlen,
   output logic [2:0]                 m_arsize,
   output logic [1:0]                 m_arburst,
   output logic [1:0]                 m_arlock,
   output logic [3:0]                 m_arcache,
   output logic [2:0]                 m_arprot,
   output logic                       m_arvalid,
   input  logic                       m_arready,
   input  logic [ID_W-1:0]            m_rid,
   input  logic [DATA_W-1:0]          m_rdata,
   input  logic [1:0]                 m_rresp,
   input  logic                       m_rlast,
   input  logic                       m_rvalid,
   output logic                       m_rready,
   // downstream write
   output logic [ID_W-1:0]            m_awid,
   output logic [ADDR_W-1:0]          m_awaddr,
   output logic [7:0]                 m_awlen,
   output logic [2:0]                 m_awsize,
   output logic [1:0]                 m_awburst,
   output logic [1:0]                 m_awlock,
   output logic [3:0]                 m_awcache,
   output logic [2:0]                 m_awprot,
   output logic                       m_awvalid,
   input  logic                       m_awready,
   output logic [ID_W-1:0]            m_wid,
   output logic [DATA_W-1:0]          m_wdata,
   output logic [DATA_W/8-1:0]        m_wstrb,
   output logic                       m_wlast,
   output logic                       m_wvalid,
   input  logic                       m_wready,
   input  logic [ID_W-1:0]            m_bid,
   input  logic [1:0]                 m_bresp,
   input  logic                       m_bvalid,
   output logic                       m_bready
);

   localparam int STRB_W = DATA_W / 8;
   localparam int GW     = (N_MST > 1) ? $clog2(N_MST) : 1;

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

   rd_state_e         rd_state_q, rd_state_d;
   wr_state_e         wr_state_q, wr_state_d;
   logic [GW-1:0]     rgnt_q, rgnt_d, rptr_q, rptr_d;
   logic [GW-1:0]     wgnt_q, wgnt_d, wptr_q, wptr_d;

   // Only one transaction is ever outstanding per path, so response IDs carry no routing info.
   logic unused_ids;
   assign unused_ids = ^{m_rid, m_bid};

   function automatic logic [GW-1:0] rr_pick(input logic [N_MST-1:0] req, input logic [GW-1:0] ptr);
      logic [GW-1:0] pick_hi, pick_lo;
      logic          found_hi;
      pick_hi  = '0;
      pick_lo  = '0;
      found_hi = 1'b0;
      for (int i = N_MST - 1; i >= 0; i--) begin
         if (req[i]) begin
            pick_lo = GW'(i);
            if (GW'(i) >= ptr) begin
               pick_hi  = GW'(i);
               found_hi = 1'b1;
            end
         end
      end
      return found_hi ? pick_hi : pick_lo;
   endfunction

   function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] g);
      return (g == GW'(N_MST - 1)) ? '0 : g + 1'b1;
   endfunction

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_state_q <= R_IDLE;
         rgnt_q     <= '0;
         rptr_q     <= '0;
         wr_state_q <= W_IDLE;
         wgnt_q     <= '0;
         wptr_q     <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         rgnt_q     <= rgnt_d;
         rptr_q     <= rptr_d;
         wr_state_q <= wr_state_d;
         wgnt_q     <= wgnt_d;
         wptr_q     <= wptr_d;
      end
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rgnt_d     = rgnt_q;
      rptr_d     = rptr_q;
      s_arready  = '0;
      m_arvalid  = 1'b0;
      m_arid     = '0;
      m_araddr   = '0;
      m_arlen    = '0;
      m_arsize   = '0;
      m_arburst  = '0;
      m_arlock   = '0;
      m_arcache  = '0;
      m_arprot   = '0;
      s_rvalid   = '0;
      m_rready   = 1'b0;
      s_rdata    = '0;
      s_rresp    = '0;
      s_rlast    = 1'b0;
      case (rd_state_q)
         R_IDLE: begin
            if (|s_arvalid) begin
               rgnt_d     = rr_pick(s_arvalid, rptr_q);
               rd_state_d = R_ADDR;
            end
         end
         R_ADDR: begin
            m_arvalid         = s_arvalid[rgnt_q];
            s_arready[rgnt_q] = m_arready;
            m_arid            = ID_W'(rgnt_q);
            m_araddr          = s_araddr[int'(rgnt_q)*ADDR_W +: ADDR_W];
            m_arlen           = s_arlen[int'(rgnt_q)*8 +: 8];
            m_arsize          = s_arsize[int'(rgnt_q)*3 +: 3];
            m_arburst         = 2'b01;
            if (m_arvalid && m_arready) rd_state_d = R_DATA;
         end
         R_DATA: begin
            s_rvalid[rgnt_q] = m_rvalid;
            m_rready         = s_rready[rgnt_q];
            s_rdata          = m_rdata;
            s_rresp          = m_rresp;
            s_rlast          = m_rlast;
            if (m_rvalid && m_rready && m_rlast) begin
               rd_state_d = R_IDLE;
               rptr_d     = rr_next(rgnt_q);
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      wr_state_d = wr_state_q;
      wgnt_d     = wgnt_q;
      wptr_d     = wptr_q;
      s_awready  = '0;
      m_awvalid  = 1'b0;
      m_awid     = '0;
      m_awaddr   = '0;
      m_awlen    = '0;
      m_awsize   = '0;
      m_awburst  = '0;
      m_awlock   = '0;
      m_awcache  = '0;
      m_awprot   = '0;
      s_wready   = '0;
      m_wvalid   = 1'b0;
      m_wid      = '0;
      m_wdata    = '0;
      m_wstrb    = '0;
      m_wlast    = 1'b0;
      s_bvalid   = '0;
      m_bready   = 1'b0;
      s_bresp    = '0;
      case (wr_state_q)
         W_IDLE: begin
            if (|s_awvalid) begin
               wgnt_d     = rr_pick(s_awvalid, wptr_q);
               wr_state_d = W_ADDR;
            end
         end
         W_ADDR: begin
            m_awvalid         = s_awvalid[wgnt_q];
            s_awready[wgnt_q] = m_awready;
            m_awid            = ID_W'(wgnt_q);
            m_awaddr          = s_awaddr[int'(wgnt_q)*ADDR_W +: ADDR_W];
            m_awlen           = s_awlen[int'(wgnt_q)*8 +: 8];
            m_awsize          = s_awsize[int'(wgnt_q)*3 +: 3];
            m_awburst         = 2'b01;
            if (m_awvalid && m_awready) wr_state_d = W_DATA;
         end
         W_DATA: begin
            m_wvalid         = s_wvalid[wgnt_q];
            s_wready[wgnt_q] = m_wready;
            m_wid            = ID_W'(wgnt_q);
            m_wdata          = s_wdata[int'(wgnt_q)*DATA_W +: DATA_W];
            m_wstrb          = s_wstrb[int'(wgnt_q)*STRB_W +: STRB_W];
            m_wlast          = s_wlast[wgnt_q];
            if (m_wvalid && m_wready && m_wlast) wr_state_d = W_RESP;
         end
         W_RESP: begin
            s_bvalid[wgnt_q] = m_bvalid;
            m_bready         = s_bready[wgnt_q];
            s_bresp          = m_bresp;
            if (m_bvalid && m_bready) begin
               wr_state_d = W_IDLE;
               wptr_d     = rr_next(wgnt_q);
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi_nmaster_arbiter.sv
// Bench for axi_nmaster_arbiter: per-path transaction model (round-robin pick,
// beat lists, routing expectations) driven with randomized data, lengths and stalls.
module tb_axi_nmaster_arbiter;
   localparam int N = 3, AW = 32, DW = 32, IW = 4, SW = DW / 8;

   logic clk = 1'b0, rstn = 1'b0;
   logic [N-1:0] s_arvalid, s_arready, s_rvalid, s_rready;
   logic [N*AW-1:0] s_araddr, s_awaddr;
   logic [N*8-1:0] s_arlen, s_awlen;
   logic [N*3-1:0] s_arsize, s_awsize;
   logic [DW-1:0] s_rdata;
   logic [1:0] s_rresp, s_bresp;
   logic s_rlast;
   logic [N-1:0] s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [N*DW-1:0] s_wdata;
   logic [N*SW-1:0] s_wstrb;
   logic [IW-1:0] m_arid, m_rid, m_awid, m_wid, m_bid;
   logic [AW-1:0] m_araddr, m_awaddr;
   logic [7:0] m_arlen, m_awlen;
   logic [2:0] m_arsize, m_arprot, m_awsize, m_awprot;
   logic [1:0] m_arburst, m_arlock, m_awburst, m_awlock, m_rresp, m_bresp;
   logic [3:0] m_arcache, m_awcache;
   logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
   logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
   logic [DW-1:0] m_rdata, m_wdata;
   logic [SW-1:0] m_wstrb;
   logic out_or;

   int checks = 0, errors = 0;
   int rptr_m = 0, wptr_m = 0;

   axi_nmaster_arbiter #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
      .aclk(clk), .aresetn(rstn),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
      .s_arsize(s_arsize), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
      .s_awsize(s_awsize), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
      .s_bready(s_bready),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
      .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
      .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
      .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
   );

   always #5 clk = ~clk;

   assign out_or = |{s_arready, s_rdata, s_rresp, s_rlast, s_rvalid, s_awready, s_wready,
                     s_bresp, s_bvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst,
                     m_arlock, m_arcache, m_arprot, m_arvalid, m_rready, m_awid, m_awaddr,
                     m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awvalid,
                     m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Cyclic search from the pointer: the first pending master at or after ptr wins.
   function automatic int rr_pick(input logic [N-1:0] p, input int ptr);
      for (int k = 0; k < N; k++)
         if (p[(ptr + k) % N]) return (ptr + k) % N;
      return 0;
   endfunction

   function automatic logic [N-1:0] onehot(input bit v, input int g);
      logic [N-1:0] r;
      r = '0;
      if (v) r[g] = 1'b1;
      return r;
   endfunction

   task automatic clear_inputs();
      s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_rready = '0;
      s_awvalid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0;
      s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
      m_arready = 0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rvalid = 0;
      m_awready = 0; m_wready = 0; m_bid = '0; m_bresp = '0; m_bvalid = 0;
   endtask

   task automatic read_round(input logic [N-1:0] req, input bit stall, input int len_fix,
                             input logic [AW-1:0] addr_fix, input int abort_after);
      logic [N-1:0] pend;
      logic [AW-1:0] addr [N];
      logic [7:0] len [N];
      logic [2:0] sz [N];
      logic [DW-1:0] rd;
      logic [1:0] rr;
      int g, cyc, beats;
      bit hs, seen, first;
      pend = req;
      first = 1;
      @(negedge clk);
      for (int m = 0; m < N; m++) begin
         addr[m] = (len_fix >= 0) ? addr_fix : $urandom;
         len[m]  = (len_fix >= 0) ? 8'(len_fix) : 8'($urandom_range(0, 5));
         sz[m]   = 3'($urandom_range(0, 3));
         s_araddr[m*AW +: AW] = addr[m];
         s_arlen[m*8 +: 8]    = len[m];
         s_arsize[m*3 +: 3]   = sz[m];
      end
      s_arvalid = req;
      #1 chk("ar_not_early", m_arvalid, 0);
      while (pend != 0) begin
         g = rr_pick(pend, rptr_m);
         hs = 0; seen = 0; cyc = 0;
         while (!hs) begin
            @(negedge clk);
            m_arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
            #1;
            if (m_arvalid) begin
               if (!seen) begin
                  seen = 1;
                  if (first) chk("ar_latency", cyc, 1);
                  chk("arid", m_arid, g);
                  chk("araddr", m_araddr, addr[g]);
                  chk("arlen", m_arlen, len[g]);
                  chk("arsize", m_arsize, sz[g]);
                  chk("ar_fixed", {m_arburst, m_arlock, m_arcache, m_arprot}, {2'b01, 9'h0});
               end
               chk("s_arready", s_arready, onehot(m_arready, g));
               hs = m_arready;
            end else chk("s_arready_noreq", s_arready, 0);
            if (!hs && cyc > 100) begin chk("ar_timeout", hs, 1); return; end
         end
         first = 0;
         beats = 0; cyc = 0; hs = 0;
         rd = $urandom; rr = 2'($urandom);
         while (!hs) begin
            @(negedge clk);
            s_arvalid[g] = 1'b0;
            m_arready = 1'b0;
            m_rvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            m_rdata = rd; m_rresp = rr; m_rid = IW'($urandom);
            m_rlast = (beats == int'(len[g]));
            s_rready = stall ? N'($urandom) : '1;
            cyc++;
            #1;
            chk("s_rvalid", s_rvalid, onehot(m_rvalid, g));
            chk("m_rready", m_rready, s_rready[g]);
            if (m_rvalid && s_rready[g]) begin
               chk("rdata", s_rdata, rd);
               chk("rresp", s_rresp, rr);
               chk("rlast", s_rlast, beats == int'(len[g]));
               beats++;
               rd = $urandom; rr = 2'($urandom);
               if (beats == abort_after) return;
               hs = (beats == int'(len[g]) + 1);
            end
            if (!hs && cyc > 200) begin chk("r_timeout", hs, 1); return; end
         end
         rptr_m = (g + 1) % N;
         pend[g] = 1'b0;
      end
      @(negedge clk);
      m_rvalid = 1'b1; s_rready = '1;
      #1;
      chk("r_idle_rvalid", s_rvalid, 0);
      chk("r_idle_rready", m_rready, 0);
      m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = '0;
   endtask

   task automatic write_round(input logic [N-1:0] req, input bit stall, input int len_fix);
      logic [N-1:0] pend;
      logic [AW-1:0] addr [N];
      logic [7:0] len [N];
      logic [2:0] sz [N];
      logic [DW-1:0] wd [N][8];
      logic [SW-1:0] ws [N][8];
      logic [1:0] br;
      int g, cyc, beats;
      bit hs, seen, first;
      pend = req;
      first = 1;
      @(negedge clk);
      for (int m = 0; m < N; m++) begin
         addr[m] = $urandom;
         len[m]  = (len_fix >= 0) ? 8'(len_fix) : 8'($urandom_range(0, 5));
         sz[m]   = 3'($urandom_range(0, 3));
         for (int b = 0; b < 8; b++) begin
            wd[m][b] = $urandom;
            ws[m][b] = SW'($urandom);
         end
         s_awaddr[m*AW +: AW] = addr[m];
         s_awlen[m*8 +: 8]    = len[m];
         s_awsize[m*3 +: 3]   = sz[m];
         s_wdata[m*DW +: DW]  = wd[m][0];
         s_wstrb[m*SW +: SW]  = ws[m][0];
         s_wlast[m]           = (len[m] == 0);
      end
      s_awvalid = req;
      s_wvalid  = req;
      #1 chk("aw_not_early", m_awvalid, 0);
      while (pend != 0) begin
         g = rr_pick(pend, wptr_m);
         hs = 0; seen = 0; cyc = 0;
         while (!hs) begin
            @(negedge clk);
            m_bvalid = 1'b0;
            m_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
            #1;
            chk("s_wready_before_aw", s_wready, 0);
            chk("m_wvalid_before_aw", m_wvalid, 0);
            if (m_awvalid) begin
               if (!seen) begin
                  seen = 1;
                  if (first) chk("aw_latency", cyc, 1);
                  chk("awid", m_awid, g);
                  chk("awaddr", m_awaddr, addr[g]);
                  chk("awlen", m_awlen, len[g]);
                  chk("awsize", m_awsize, sz[g]);
                  chk("aw_fixed", {m_awburst, m_awlock, m_awcache, m_awprot}, {2'b01, 9'h0});
               end
               chk("s_awready", s_awready, onehot(m_awready, g));
               hs = m_awready;
            end else chk("s_awready_noreq", s_awready, 0);
            if (!hs && cyc > 100) begin chk("aw_timeout", hs, 1); return; end
         end
         first = 0;
         beats = 0; cyc = 0; hs = 0;
         while (!hs) begin
            @(negedge clk);
            s_awvalid[g] = 1'b0;
            m_awready = 1'b0;
            s_wvalid[g] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            s_wdata[g*DW +: DW] = wd[g][beats];
            s_wstrb[g*SW +: SW] = ws[g][beats];
            s_wlast[g] = (beats == int'(len[g]));
            m_wready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
            #1;
            chk("m_wvalid", m_wvalid, s_wvalid[g]);
            chk("s_wready", s_wready, onehot(m_wready, g));
            if (m_wvalid) begin
               chk("wid", m_wid, g);
               chk("wdata", m_wdata, wd[g][beats]);
               chk("wstrb", m_wstrb, ws[g][beats]);
               chk("wlast", m_wlast, beats == int'(len[g]));
            end
            if (s_wvalid[g] && m_wready) begin
               beats++;
               hs = (beats == int'(len[g]) + 1);
            end
            if (!hs && cyc > 200) begin chk("w_timeout", hs, 1); return; end
         end
         br = 2'($urandom); cyc = 0; hs = 0;
         while (!hs) begin
            @(negedge clk);
            s_wvalid[g] = 1'b0;
            m_wready = 1'b0;
            m_bvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            m_bresp = br; m_bid = IW'($urandom);
            s_bready = stall ? N'($urandom) : '1;
            cyc++;
            #1;
            chk("s_bvalid", s_bvalid, onehot(m_bvalid, g));
            chk("m_bready", m_bready, s_bready[g]);
            if (m_bvalid) chk("bresp", s_bresp, br);
            hs = m_bvalid && s_bready[g];
            if (!hs && cyc > 100) begin chk("b_timeout", hs, 1); return; end
         end
         wptr_m = (g + 1) % N;
         pend[g] = 1'b0;
      end
      @(negedge clk);
      m_bvalid = 1'b1; s_bready = '1; m_wready = 1'b1;
      #1;
      chk("w_idle_bvalid", s_bvalid, 0);
      chk("w_idle_bready", m_bready, 0);
      chk("w_idle_wready", s_wready, 0);
      m_bvalid = 1'b0; s_bready = '0; m_wready = 1'b0;
   endtask

   initial begin
      logic [N-1:0] rq, wq;
      clear_inputs();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_outputs_zero", out_or, 0);
      @(negedge clk);
      rstn = 1'b1;

      // directed single read from master 1, then plain round-robin rounds
      read_round(3'b010, 1'b0, 3, 32'h1FC0_0000, -1);
      read_round(3'b111, 1'b0, -1, '0, -1);
      read_round(3'b111, 1'b1, -1, '0, -1);

      // write from master 2 with W presented early, then pointer wrap to 0
      write_round(3'b100, 1'b0, 1);
      write_round(3'b111, 1'b0, -1);

      // concurrent read and write, address handshakes in the same cycle
      fork
         read_round(3'b001, 1'b0, -1, '0, -1);
         write_round(3'b100, 1'b0, -1);
      join

      // random request sets under backpressure on both paths
      for (int i = 0; i < 8; i++) begin
         rq = N'($urandom_range(1, 7));
         wq = N'($urandom_range(1, 7));
         fork
            read_round(rq, 1'b1, -1, '0, -1);
            write_round(wq, 1'b1, -1);
         join
      end

      // reset in the middle of a read burst, pointer left nonzero beforehand
      read_round(3'b001, 1'b0, -1, '0, -1);
      read_round(3'b010, 1'b0, 3, 32'h2000_0000, 2);
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      chk("midrst_outputs_zero", out_or, 0);
      chk("midrst_rvalid", s_rvalid, 0);
      chk("midrst_rready", m_rready, 0);
      clear_inputs();
      rptr_m = 0;
      wptr_m = 0;
      @(negedge clk);
      rstn = 1'b1;
      read_round(3'b111, 1'b0, -1, '0, -1);
      write_round(3'b111, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
